qpi_bus_arbiter: RTL

QPI_BUS_ARBITER -- requirements
Module: qpi_bus_arbiter

---
 rtl/qpi_bus_arbiter.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/qpi_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : qpi_bus_arbiter
//  Purpose  : Two-master arbiter for a shared QPI bus (SPI flash + ML
//             accelerator). Grants the bus round-robin, inserts GUARD_CYCLES
//             idle cycles between owners and muxes the pin set
//             combinationally from the registered state.
//  Ports    : clk, reset (async, active-high)
//             f_*/m_*   : per-master req/gnt, QPI clk, csb, do, oe, di
//             bus_*     : shared QPI pins (clk, do, oe, di)
//             flash_csb, ml_csb : per-device chip selects
//             owner, busy, timeout : status
//  Options  : `define QPI_ARB_TIMEOUT_EN bounds every grant to MAX_HOLD cycles
//             and blocks the timed-out master until its req has gone low.
//  Revision : 1.0 - initial release
// ============================================================================
module qpi_bus_arbiter #(
    parameter int GUARD_CYCLES = 2,
    parameter int MAX_HOLD     = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       f_req,
    input  logic       m_req,
    output logic       f_gnt,
    output logic       m_gnt,
    input  logic       f_clk,
    input  logic       m_clk,
    input  logic       f_csb,
    input  logic       m_csb,
    input  logic [3:0] f_do,
    input  logic [3:0] m_do,
    input  logic [3:0] f_oe,
    input  logic [3:0] m_oe,
    output logic [3:0] f_di,
    output logic [3:0] m_di,
    output logic       bus_clk,
    output logic       flash_csb,
    output logic       ml_csb,
    output logic [3:0] bus_do,
    output logic [3:0] bus_oe,
    input  logic [3:0] bus_di,
    output logic       owner,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_F = 2'd1,
        ST_GRANT_M = 2'd2,
        ST_GUARD   = 2'd3
    } state_t;

    localparam logic [3:0] C_GUARD_LAST = 4'(GUARD_CYCLES - 1);

    state_t     state_q, state_d;
    logic       last_m_q, last_m_d;     // 1: ML master was granted last
    logic       owner_q, owner_d;
    logic [3:0] guard_cnt_q, guard_cnt_d;

    logic       w_f_req_eff;            // requests after timeout blocking
    logic       w_m_req_eff;
    logic       w_hold_exp;             // current grant reached its limit
    logic       w_timeout_fire;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_m_q    <= 1'b1;        // makes flash win the first contention
            owner_q     <= 1'b0;
            guard_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            last_m_q    <= last_m_d;
            owner_q     <= owner_d;
            guard_cnt_q <= guard_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        last_m_d       = last_m_q;
        owner_d        = owner_q;
        guard_cnt_d    = guard_cnt_q;
        w_timeout_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_f_req_eff && (!w_m_req_eff || last_m_q)) begin
                    state_d  = ST_GRANT_F;
                    last_m_d = 1'b0;
                    owner_d  = 1'b0;
                end else if (w_m_req_eff) begin
                    state_d  = ST_GRANT_M;
                    last_m_d = 1'b1;
                    owner_d  = 1'b1;
                end
            end
            ST_GRANT_F: begin
                // Only the owner's req matters here; a normal release
                // takes precedence over a coincident timeout.
                if (!f_req) begin
                    state_d     = ST_GUARD;
                    guard_cnt_d = C_GUARD_LAST;
                end else if (w_hold_exp) begin
                    state_d        = ST_GUARD;
                    guard_cnt_d    = C_GUARD_LAST;
                    w_timeout_fire = 1'b1;
                end
            end
            ST_GRANT_M: begin
                if (!m_req) begin
                    state_d     = ST_GUARD;
                    guard_cnt_d = C_GUARD_LAST;
                end else if (w_hold_exp) begin
                    state_d        = ST_GUARD;
                    guard_cnt_d    = C_GUARD_LAST;
                    w_timeout_fire = 1'b1;
                end
            end
            ST_GUARD: begin
                if (guard_cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef QPI_ARB_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt_q;
    logic              timeout_q;
    logic              blk_f_q;         // master timed out, awaiting req low
    logic              blk_m_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
            blk_f_q    <= 1'b0;
            blk_m_q    <= 1'b0;
        end else begin
            timeout_q <= w_timeout_fire;
            // Grants are only entered from IDLE, so clearing there means
            // the count starts at zero on the first grant cycle.
            if (state_q == ST_IDLE) begin
                hold_cnt_q <= '0;
            end else if ((state_q == ST_GRANT_F || state_q == ST_GRANT_M) && !w_hold_exp) begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end
            if (w_timeout_fire && state_q == ST_GRANT_F) begin
                blk_f_q <= 1'b1;
            end else if (state_q == ST_IDLE && !f_req) begin
                blk_f_q <= 1'b0;
            end
            if (w_timeout_fire && state_q == ST_GRANT_M) begin
                blk_m_q <= 1'b1;
            end else if (state_q == ST_IDLE && !m_req) begin
                blk_m_q <= 1'b0;
            end
        end
    end

    assign w_hold_exp  = (hold_cnt_q == C_HOLD_LAST);
    assign w_f_req_eff = f_req & ~blk_f_q;
    assign w_m_req_eff = m_req & ~blk_m_q;
    assign timeout     = timeout_q;
`else
    logic w_unused_cfg;

    assign w_hold_exp   = 1'b0;
    assign w_f_req_eff  = f_req;
    assign w_m_req_eff  = m_req;
    assign timeout      = 1'b0;
    assign w_unused_cfg = w_timeout_fire | (MAX_HOLD > 0);
`endif

    // ------------------------------------------------------------------
    // Pin mux: purely combinational from state_q, so reset idles the pins
    // immediately and no pin path picks up a register stage.
    // ------------------------------------------------------------------
    always_comb begin
        bus_clk   = 1'b0;
        bus_do    = 4'h0;
        bus_oe    = 4'h0;
        flash_csb = 1'b1;
        ml_csb    = 1'b1;
        f_di      = 4'h0;
        m_di      = 4'h0;
        case (state_q)
            ST_GRANT_F: begin
                bus_clk   = f_clk;
                bus_do    = f_do;
                bus_oe    = f_oe;
                flash_csb = f_csb;
                f_di      = bus_di;
            end
            ST_GRANT_M: begin
                bus_clk = m_clk;
                bus_do  = m_do;
                bus_oe  = m_oe;
                ml_csb  = m_csb;
                m_di    = bus_di;
            end
            default: ;
        endcase
    end

    assign f_gnt = (state_q == ST_GRANT_F);
    assign m_gnt = (state_q == ST_GRANT_M);
    assign busy  = (state_q != ST_IDLE);
    assign owner = owner_q;

endmodule
`default_nettype wire
